divisor8x8: RTL and testbench

//  Sequential 8-bit unsigned divider: Quociente = A / B, Resto = A % B, by repeated subtraction.

---
 rtl/ula_defs.sv | 17 +
 rtl/subtrator8bits.sv | 31 +++
 rtl/divisor8x8.sv | 94 +++++++++
 tb/tb_divisor8x8.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ula_defs.sv
// ula_defs: shared definitions for the RPN ULA datapath (operand width, FSM encodings).
// Rev 1.0
`default_nettype none

package ula_defs;

  localparam int LARGURA_PADRAO = 8;

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    SUBTRAINDO = 2'b01,
    CONCLUIDO  = 2'b10
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/subtrator8bits.sv
// subtrator8bits: ripple-borrow subtractor, Diferenca = X - Y, Borrow = 1 when X < Y.
// Rev 1.0
`default_nettype none

module subtrator8bits
  import ula_defs::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [LARGURA-1:0] X,
  input  logic [LARGURA-1:0] Y,
  output logic [LARGURA-1:0] Diferenca,
  output logic               Borrow
);

  logic [LARGURA:0] borrow_chain;

  assign borrow_chain[0] = 1'b0;

  generate
    for (genvar i = 0; i < LARGURA; i++) begin : g_bit
      assign Diferenca[i]       = X[i] ^ Y[i] ^ borrow_chain[i];
      assign borrow_chain[i+1]  = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & borrow_chain[i]);
    end
  endgenerate

  assign Borrow = borrow_chain[LARGURA];

endmodule

`default_nettype wire

// File: rtl/divisor8x8.sv
// divisor8x8: sequential unsigned divider by repeated subtraction with START/Pronto handshake.
// Rev 1.0
`default_nettype none

module divisor8x8
  import ula_defs::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic [LARGURA-1:0] Quociente,
  output logic [LARGURA-1:0] Resto,
  output logic               DivZero,
  output logic               Pronto
);

  estado_t            state, state_nxt;
  logic [LARGURA-1:0] divisor, divisor_nxt;
  logic [LARGURA-1:0] resto, resto_nxt;
  logic [LARGURA-1:0] quoc, quoc_nxt;
  logic               div_zero, div_zero_nxt;
  logic [LARGURA-1:0] diferenca;
  logic               borrow;

  // The borrow-out doubles as the Resto >= Divisor comparison.
  subtrator8bits #(.LARGURA(LARGURA)) u_sub (
    .X         (resto),
    .Y         (divisor),
    .Diferenca (diferenca),
    .Borrow    (borrow)
  );

  always_comb begin
    state_nxt    = state;
    divisor_nxt  = divisor;
    resto_nxt    = resto;
    quoc_nxt     = quoc;
    div_zero_nxt = div_zero;
    if (START) begin
      divisor_nxt = B;
      resto_nxt   = A;
      if (B == '0) begin
        div_zero_nxt = 1'b1;
        quoc_nxt     = '1;
        state_nxt    = CONCLUIDO;
      end else begin
        div_zero_nxt = 1'b0;
        quoc_nxt     = '0;
        state_nxt    = SUBTRAINDO;
      end
    end else begin
      case (state)
        SUBTRAINDO: begin
          if (!borrow) begin
            resto_nxt = diferenca;
            quoc_nxt  = quoc + LARGURA'(1);
          end else begin
            state_nxt = CONCLUIDO;
          end
        end
        CONCLUIDO: state_nxt = CONCLUIDO;
        default:   state_nxt = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= OCIOSO;
      divisor  <= '0;
      resto    <= '0;
      quoc     <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      divisor  <= divisor_nxt;
      resto    <= resto_nxt;
      quoc     <= quoc_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  assign Quociente = quoc;
  assign Resto     = resto;
  assign DivZero   = div_zero;
  assign Pronto    = (state == CONCLUIDO);

endmodule

`default_nettype wire

// File: tb/tb_divisor8x8.sv
// tb_divisor8x8: randomized and directed checks of divisor8x8 against an arithmetic reference.
// Rev 1.0
`default_nettype none

module tb_divisor8x8;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic [7:0] Quociente;
  logic [7:0] Resto;
  logic       DivZero;
  logic       Pronto;

  int n_checks = 0;
  int n_pass   = 0;

  divisor8x8 dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .START     (START),
    .A         (A),
    .B         (B),
    .Quociente (Quociente),
    .Resto     (Resto),
    .DivZero   (DivZero),
    .Pronto    (Pronto)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Starts a division (START held for 'hold' edges) and checks latency and results.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int hold);
    int  q_exp, r_exp, lat_exp, lat;
    bit  found;
    q_exp   = (b == 0) ? 255 : int'(a) / int'(b);
    r_exp   = (b == 0) ? int'(a) : int'(a) % int'(b);
    lat_exp = (b == 0) ? 0 : q_exp + 1;
    @(negedge CLOCK);
    START = 1'b1; A = a; B = b;
    for (int i = 1; i < hold; i++) begin
      @(negedge CLOCK);
      if (b != 0) check({tag, "/held_pronto"}, int'(Pronto), 0);
    end
    @(posedge CLOCK);
    @(negedge CLOCK);
    START = 1'b0; A = 8'($urandom); B = 8'($urandom);
    lat   = 0;
    found = Pronto;
    while (!found && lat < 300) begin
      @(posedge CLOCK);
      lat++;
      @(negedge CLOCK);
      A = 8'($urandom); B = 8'($urandom);
      found = Pronto;
    end
    check({tag, "/latency"}, found ? lat : -1, lat_exp);
    check({tag, "/quociente"}, int'(Quociente), q_exp);
    check({tag, "/resto"}, int'(Resto), r_exp);
    check({tag, "/divzero"}, int'(DivZero), (b == 0) ? 1 : 0);
    repeat (3) @(negedge CLOCK);
    check({tag, "/stable_pronto"}, int'(Pronto), 1);
    check({tag, "/stable_quoc"}, int'(Quociente), q_exp);
  endtask

  initial begin
    logic [7:0] ra, rb;

    #12;
    check("reset/quociente", int'(Quociente), 0);
    check("reset/resto", int'(Resto), 0);
    check("reset/divzero", int'(DivZero), 0);
    check("reset/pronto", int'(Pronto), 0);
    @(negedge CLOCK);
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    check("idle/pronto", int'(Pronto), 0);

    run_div("d100_7", 8'd100, 8'd7, 1);
    run_div("d5_9", 8'd5, 8'd9, 1);
    run_div("d255_255", 8'd255, 8'd255, 1);
    run_div("d200_0", 8'd200, 8'd0, 1);
    run_div("d10_3", 8'd10, 8'd3, 1);
    run_div("d255_1", 8'd255, 8'd1, 1);
    run_div("held50_6", 8'd50, 8'd6, 3);

    // Abort: long run restarted by a second START a few edges in.
    @(negedge CLOCK);
    START = 1'b1; A = 8'd255; B = 8'd1;
    @(negedge CLOCK);
    START = 1'b0;
    repeat (8) @(negedge CLOCK);
    check("abort/mid_pronto", int'(Pronto), 0);
    run_div("abort9_3", 8'd9, 8'd3, 1);

    // Asynchronous reset between edges during a division.
    @(negedge CLOCK);
    START = 1'b1; A = 8'd255; B = 8'd1;
    @(negedge CLOCK);
    START = 1'b0;
    repeat (5) @(negedge CLOCK);
    #1 RESET = 1'b0;
    #1;
    check("arst/quociente", int'(Quociente), 0);
    check("arst/resto", int'(Resto), 0);
    check("arst/divzero", int'(DivZero), 0);
    check("arst/pronto", int'(Pronto), 0);
    #1 RESET = 1'b1;
    repeat (5) @(negedge CLOCK);
    check("arst/after_pronto", int'(Pronto), 0);
    check("arst/after_quoc", int'(Quociente), 0);

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) rb = 8'($urandom_range(1, 12));
      run_div($sformatf("rnd%0d_%0d_%0d", n, ra, rb), ra, rb, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
